coherent_sum_writer: RTL

Buffers the per-dump coherent sums produced by the correlator's dumping logic (`coherent_sum_valid`, `cor_index`, `i_coherent_sum`, `q_coherent_sum`) and writes them into the shared coherent-data RAM. The RAM port is reached through a request/grant handshake shared with the CPU. A new coherent period (`cor_index[0]=1`) is a direct write. A continuing period (`cor_index[0]=0`) is a saturating read-modify-write accumulate. The block sits between the correlator datapath and the coherent buffer arbiter. It lets bursts of up to 8 correlator dumps land without stalling the correlator.

---
 rtl/coherent_sum_writer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/coherent_sum_writer.sv
// coherent_sum_writer: queues correlator coherent-sum dumps and writes them into the
// shared coherent RAM, either directly or as a saturating read-modify-write accumulate.
module coherent_sum_writer #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  channel_start,
    input  logic [ADDR_WIDTH-1:0] coh_base_addr,
    input  logic                  channel_done,
    input  logic                  coherent_sum_valid,
    input  logic [4:0]            cor_index,
    input  logic [15:0]           i_coherent_sum,
    input  logic [15:0]           q_coherent_sum,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic [31:0]           mem_rdata,
    input  logic                  status_clear,
    output logic                  busy,
    output logic                  flush_done,
    output logic                  fifo_overflow,
    output logic                  sat_flag,
    output logic                  overwrite_seen
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  ow;
        logic                  nw;
        logic [15:0]           i;
        logic [15:0]           q;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic                  pending_q, pending_d;
    logic                  ovf_q, sat_q, ow_q;

    entry_t                fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q;

    entry_t                head, push_entry;
    logic                  full, empty, push, pop;
    logic                  sat_evt, flush_fire;
    logic [16:0]           acc_i, acc_q;

    // Bit 16 of the result flags that the 17-bit signed sum was clamped.
    function automatic logic [16:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        if (s[16] != s[15]) begin
            return {1'b1, (s[16] ? 16'h8000 : 16'h7FFF)};
        end
        return {1'b0, s[15:0]};
    endfunction

    assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = coherent_sum_valid & ~full;
    assign pop   = (state_q == WR_REQ) & mem_gnt;
    assign head  = fifo_q[rd_ptr_q];

    // Address uses the base held before any same-cycle channel_start update.
    assign push_entry = '{addr: base_q + ADDR_WIDTH'(cor_index[4:2]),
                          ow:   cor_index[1],
                          nw:   cor_index[0],
                          i:    i_coherent_sum,
                          q:    q_coherent_sum};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign acc_i = sat_add(mem_rdata[31:16], head.i);
    assign acc_q = sat_add(mem_rdata[15:0],  head.q);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        sat_evt     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    mem_addr_d = head.addr;
                    if (head.nw) begin
                        mem_wdata_d = {head.i, head.q};
                        state_d     = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                if (mem_gnt) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                mem_wdata_d = {acc_i[15:0], acc_q[15:0]};
                sat_evt     = acc_i[16] | acc_q[16];
                state_d     = WR_REQ;
            end
            WR_REQ: begin
                if (mem_gnt) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flush_fire = pending_q & empty & (state_q == IDLE);
    assign pending_d  = flush_fire ? 1'b0 : (pending_q | channel_done);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            pending_q   <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
            ow_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            pending_q   <= pending_d;
            if (channel_start) base_q <= coh_base_addr;
            // A set event in the same cycle as status_clear wins.
            ovf_q <= (coherent_sum_valid & full) | (ovf_q & ~status_clear);
            sat_q <= sat_evt | (sat_q & ~status_clear);
            ow_q  <= (pop & head.ow) | (ow_q & ~status_clear);
        end
    end

    assign mem_req        = (state_q == RD_REQ) | (state_q == WR_REQ);
    assign mem_we         = (state_q == WR_REQ);
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign busy           = ~empty | (state_q != IDLE);
    assign flush_done     = flush_fire;
    assign fifo_overflow  = ovf_q;
    assign sat_flag       = sat_q;
    assign overwrite_seen = ow_q;

endmodule
